conv: RTL and testbench

CONV -- requirements
Module: Conv

---
 rtl/conv.sv | 86 ++++++++
 tb/tb_conv.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/conv.sv
// rtl/conv.sv - 3x3 correlation of a streamed pixel window with a Q1.7 kernel; registered 13-bit result.
// Define CONV_ROUND_EN for round-half-up output; truncation otherwise.
module conv #(
  parameter int BIT_LEN   = 8,
  parameter int CONV_LEN  = 20,
  parameter int BITS_DATA = 13
) (
  input  logic                        CLK100MHZ,
  input  logic                        i_reset,
  input  logic [BIT_LEN-1:0]          i_dato0,
  input  logic [BIT_LEN-1:0]          i_dato1,
  input  logic [BIT_LEN-1:0]          i_dato2,
  input  logic                        i_selecK_I,
  input  logic                        i_valid,
  output logic signed [BITS_DATA-1:0] o_data
);

  localparam int PROD_LEN = 2 * BIT_LEN + 1;
  localparam int FRAC     = CONV_LEN - BITS_DATA;

  logic [BIT_LEN-1:0] k [3][3];
  logic [BIT_LEN-1:0] w [3][3];
  logic [BIT_LEN-1:0] col [3];

  logic signed [CONV_LEN-1:0] acc;
  logic signed [CONV_LEN-1:0] acc_out;
  logic                       unused_frac;

  assign col[0] = i_dato0;
  assign col[1] = i_dato1;
  assign col[2] = i_dato2;

  // Column shift: index 0 is the oldest column, index 2 takes the new one.
  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          k[r][c] <= '0;
          w[r][c] <= '0;
        end
      end
    end else if (i_valid) begin
      for (int r = 0; r < 3; r++) begin
        if (i_selecK_I) begin
          k[r][0] <= k[r][1];
          k[r][1] <= k[r][2];
          k[r][2] <= col[r];
        end else begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
          w[r][2] <= col[r];
        end
      end
    end
  end

  // Pixels are zero-extended so the product stays signed without losing range.
  always_comb begin
    logic signed [PROD_LEN-1:0] prod;
    acc  = '0;
    prod = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod = $signed({1'b0, w[r][c]}) * $signed(k[r][c]);
        acc  = acc + {{(CONV_LEN-PROD_LEN){prod[PROD_LEN-1]}}, prod};
      end
    end
  end

`ifdef CONV_ROUND_EN
  assign acc_out = acc + CONV_LEN'(64);
`else
  assign acc_out = acc;
`endif

  assign unused_frac = ^acc_out[FRAC-1:0];

  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      o_data <= '0;
    end else begin
      o_data <= acc_out[CONV_LEN-1:FRAC];
    end
  end

endmodule

// File: tb/tb_conv.sv
// tb/tb_conv.sv - directed self-checking bench for conv; expectations hand-computed.
module tb_conv;

  logic              CLK100MHZ = 1'b0;
  logic              i_reset   = 1'b1;
  logic [7:0]        i_dato0   = '0;
  logic [7:0]        i_dato1   = '0;
  logic [7:0]        i_dato2   = '0;
  logic              i_selecK_I = 1'b0;
  logic              i_valid   = 1'b0;
  logic signed [12:0] o_data;

  int checks = 0;
  int errors = 0;
  logic signed [12:0] held;

  always #5 CLK100MHZ = ~CLK100MHZ;

  conv dut (
    .CLK100MHZ (CLK100MHZ),
    .i_reset   (i_reset),
    .i_dato0   (i_dato0),
    .i_dato1   (i_dato1),
    .i_dato2   (i_dato2),
    .i_selecK_I(i_selecK_I),
    .i_valid   (i_valid),
    .o_data    (o_data)
  );

  task automatic check(input string tag, input logic signed [12:0] expv);
    checks++;
    assert (o_data === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o_data, expv);
    end
  endtask

  // Presents one column for exactly one rising edge, returns at the following negedge.
  task automatic send(input logic sel, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    i_valid = 1'b1; i_selecK_I = sel;
    i_dato0 = a; i_dato1 = b; i_dato2 = c;
    @(negedge CLK100MHZ);
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge CLK100MHZ);
    i_reset = 1'b0;
  endtask

  task automatic settle();
    @(negedge CLK100MHZ);
  endtask

  initial begin
    @(negedge CLK100MHZ);
    do_reset();
    check("reset", 13'sd0);

    // single centre tap: 200*127/128
    send(1, 8'h00, 8'h00, 8'h00);
    send(1, 8'h00, 8'h7F, 8'h00);
    send(1, 8'h00, 8'h00, 8'h00);
    send(0, 8'd0, 8'd0, 8'd0);
    send(0, 8'd0, 8'd200, 8'd0);
    send(0, 8'd0, 8'd0, 8'd0);
    settle();
    check("centre_tap", 13'sd198);

    // all 0.5 x 255: 1147.5
    for (int i = 0; i < 3; i++) send(1, 8'h40, 8'h40, 8'h40);
    for (int i = 0; i < 3; i++) send(0, 8'd255, 8'd255, 8'd255);
    settle();
`ifdef CONV_ROUND_EN
    check("half_kernel", 13'sd1148);
`else
    check("half_kernel", 13'sd1147);
`endif

    held = o_data;
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b0;
      i_selecK_I = 1'($urandom_range(0, 1));
      i_dato0 = 8'($urandom); i_dato1 = 8'($urandom); i_dato2 = 8'($urandom);
      @(negedge CLK100MHZ);
      check("hold", held);
    end

    send(0, 8'd0, 8'd0, 8'd0);
    settle();
    check("drop_column", 13'sd765);

    // reset overrides a simultaneous valid column
    i_valid = 1'b1; i_selecK_I = 1'b1;
    i_dato0 = 8'h7F; i_dato1 = 8'h7F; i_dato2 = 8'h7F;
    do_reset();
    i_valid = 1'b0;
    check("midstream_reset", 13'sd0);
    for (int i = 0; i < 3; i++) begin
      send(0, 8'd255, 8'd255, 8'd255);
      check("no_kernel", 13'sd0);
    end

    // all -1.0 x 255: exact -2295
    for (int i = 0; i < 3; i++) send(1, 8'h80, 8'h80, 8'h80);
    settle();
    check("neg_full", 13'sd0 - 13'sd2295);

    // one kernel column after reset: 3*255*127 = 97155 -> 759
    do_reset();
    send(1, 8'h7F, 8'h7F, 8'h7F);
    for (int i = 0; i < 3; i++) send(0, 8'd255, 8'd255, 8'd255);
    settle();
    check("partial_kernel", 13'sd759);

    // interleaved kernel/image columns build diagonals: 0.5*(128+64+32) = 112
    do_reset();
    send(1, 8'h40, 8'h00, 8'h00);
    send(0, 8'd128, 8'd0, 8'd0);
    send(1, 8'h00, 8'h40, 8'h00);
    send(0, 8'd0, 8'd64, 8'd0);
    send(1, 8'h00, 8'h00, 8'h40);
    send(0, 8'd0, 8'd0, 8'd32);
    settle();
    check("interleave", 13'sd112);

    // acc = -1: truncation floors to -1, rounding gives 0
    do_reset();
    send(1, 8'h00, 8'h00, 8'h00);
    send(1, 8'h00, 8'hFF, 8'h00);
    send(1, 8'h00, 8'h00, 8'h00);
    send(0, 8'd0, 8'd0, 8'd0);
    send(0, 8'd0, 8'd1, 8'd0);
    send(0, 8'd0, 8'd0, 8'd0);
    settle();
`ifdef CONV_ROUND_EN
    check("minus_lsb", 13'sd0);
`else
    check("minus_lsb", -13'sd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
